// File: rtl/tohost_monitor_pkg.sv
// Shared definitions for the tohost completion monitor: state encoding,
// tohost value decode rules and the default tohost address.
package tohost_monitor_pkg;

  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned STRB_W     = 4;
  localparam int unsigned TEST_NUM_W = DATA_W - 1;
  localparam int unsigned CYCLE_W    = 32;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_SETTLE = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    RUN    = ST_RUN,
    SETTLE = ST_SETTLE,
    DONE   = ST_DONE
  } state_t;

  // Shared with the linker script and the benches.
  localparam logic [ADDR_W-1:0] DEFAULT_TOHOST_ADDR = 32'h0000_1000;
  localparam logic [DATA_W-1:0] PASS_CODE           = 32'h0000_0001;
  localparam logic [STRB_W-1:0] FULL_STRB           = 4'hF;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [STRB_W-1:0] strb;
  } wr_req_t;

  typedef struct packed {
    logic                  pass;
    logic                  fail;
    logic [TEST_NUM_W-1:0] test_num;
  } decode_t;

  // A completion is a full-word store of an odd value (LSB marker) to tohost;
  // even values are syscall requests and zero is the idle value.
  function automatic logic is_tohost_store(input wr_req_t req,
                                           input logic [ADDR_W-1:0] tohost_addr);
    return req.valid && (req.addr == tohost_addr) &&
           (req.strb == FULL_STRB) && req.data[0];
  endfunction

  function automatic decode_t decode_tohost(input logic [DATA_W-1:0] value);
    decode_t d;
    d.pass     = (value == PASS_CODE);
    d.fail     = !d.pass;
    d.test_num = d.pass ? '0 : value[DATA_W-1:1];
    return d;
  endfunction

endpackage

// File: rtl/tohost_monitor_if.sv
// Core data-memory write port as seen by the tohost monitor.
interface tohost_monitor_if;
  import tohost_monitor_pkg::*;

  logic              wr_valid;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [STRB_W-1:0] wr_strb;

  modport master (output wr_valid, output wr_addr, output wr_data, output wr_strb);
  modport slave  (input  wr_valid, input  wr_addr, input  wr_data, input  wr_strb);
endinterface

// File: rtl/tohost_monitor_sat_counter.sv
// Up-counter with synchronous clear that stops at MAX; sat_c flags count==MAX.
module tohost_monitor_sat_counter #(
  parameter int unsigned      WIDTH = 8,
  parameter logic [WIDTH-1:0] MAX   = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  output logic [WIDTH-1:0] count,
  output logic             sat_c
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  assign sat_c = (count_q == MAX);
  assign count = count_q;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && !sat_c) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/tohost_monitor.sv
// Snoops core stores for the riscv-tests tohost word, decodes pass/fail or
// timeout, and raises a sticky done after a short pipeline-drain interval.
module tohost_monitor
  import tohost_monitor_pkg::*;
#(
  parameter logic [ADDR_W-1:0] TOHOST_ADDR    = DEFAULT_TOHOST_ADDR,
  parameter int unsigned       TIMEOUT_CYCLES = 5000,
  parameter int unsigned       SETTLE_CYCLES  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run_en,
  tohost_monitor_if.slave       wr,
  output logic                  done,
  output logic                  done_pulse,
  output logic                  pass,
  output logic                  fail,
  output logic                  timeout,
  output logic [TEST_NUM_W-1:0] test_num,
  output logic [CYCLE_W-1:0]    cycles
);

  localparam int unsigned SETTLE_W =
    (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SETTLE_W-1:0] SETTLE_LAST   = SETTLE_W'(SETTLE_CYCLES - 1);
  localparam logic [CYCLE_W-1:0]  TIMEOUT_LAST  = CYCLE_W'(TIMEOUT_CYCLES - 1);
  localparam state_t              AFTER_DECODE  = (SETTLE_CYCLES == 0) ? DONE : SETTLE;

  if (TOHOST_ADDR[1:0] != 2'b00) begin : g_bad_tohost_addr
    $error("tohost_monitor: TOHOST_ADDR must be word aligned");
  end
  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("tohost_monitor: TIMEOUT_CYCLES must be at least 1");
  end

  state_t                state_q, state_d;
  logic                  pass_q, pass_d;
  logic                  fail_q, fail_d;
  logic                  timeout_q, timeout_d;
  logic [TEST_NUM_W-1:0] test_num_q, test_num_d;
  logic                  done_q, done_d;
  logic                  done_pulse_q, done_pulse_d;

  wr_req_t               req_c;
  decode_t               dec_c;
  logic                  hit_c;
  logic                  run_cnt_en_c, run_cnt_clr_c, run_cnt_sat_c;
  logic                  set_cnt_en_c, set_cnt_clr_c, set_cnt_sat_c;
  logic [CYCLE_W-1:0]    run_cnt;
  logic [SETTLE_W-1:0]   set_cnt;

  assign req_c = '{valid: wr.wr_valid, addr: wr.wr_addr,
                   data: wr.wr_data,   strb: wr.wr_strb};
  assign hit_c = is_tohost_store(req_c, TOHOST_ADDR);
  assign dec_c = decode_tohost(wr.wr_data);

  // The RUN counter doubles as the cycles output; it freezes once RUN is left.
  tohost_monitor_sat_counter #(.WIDTH(CYCLE_W)) u_run_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (run_cnt_en_c),
    .clr   (run_cnt_clr_c),
    .count (run_cnt),
    .sat_c (run_cnt_sat_c)
  );

  tohost_monitor_sat_counter #(.WIDTH(SETTLE_W), .MAX(SETTLE_LAST)) u_settle_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (set_cnt_en_c),
    .clr   (set_cnt_clr_c),
    .count (set_cnt),
    .sat_c (set_cnt_sat_c)
  );

  // Next-state and result capture.
  always_comb begin
    state_d       = state_q;
    pass_d        = pass_q;
    fail_d        = fail_q;
    timeout_d     = timeout_q;
    test_num_d    = test_num_q;
    run_cnt_en_c  = 1'b0;
    run_cnt_clr_c = (state_q == IDLE);
    set_cnt_en_c  = 1'b0;
    set_cnt_clr_c = (state_q != SETTLE);

    case (state_q)
      IDLE: begin
        if (run_en) state_d = RUN;
      end
      RUN: begin
        if (run_en) begin
          run_cnt_en_c = 1'b1;
          // A completion in the timeout cycle takes priority over the timeout.
          if (hit_c) begin
            pass_d     = dec_c.pass;
            fail_d     = dec_c.fail;
            test_num_d = dec_c.test_num;
            state_d    = AFTER_DECODE;
          end else if ((run_cnt == TIMEOUT_LAST) || run_cnt_sat_c) begin
            timeout_d  = 1'b1;
            state_d    = AFTER_DECODE;
          end
        end
      end
      SETTLE: begin
        set_cnt_en_c = 1'b1;
        if (set_cnt_sat_c) state_d = DONE;
      end
      DONE: begin
        state_d = DONE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    done_d       = (state_d == DONE);
    done_pulse_d = (state_d == DONE) && (state_q != DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      pass_q       <= 1'b0;
      fail_q       <= 1'b0;
      timeout_q    <= 1'b0;
      test_num_q   <= '0;
      done_q       <= 1'b0;
      done_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pass_q       <= pass_d;
      fail_q       <= fail_d;
      timeout_q    <= timeout_d;
      test_num_q   <= test_num_d;
      done_q       <= done_d;
      done_pulse_q <= done_pulse_d;
    end
  end

  assign done       = done_q;
  assign done_pulse = done_pulse_q;
  assign pass       = pass_q;
  assign fail       = fail_q;
  assign timeout    = timeout_q;
  assign test_num   = test_num_q;
  assign cycles     = run_cnt;

endmodule

// File: tb/tb_tohost_monitor.sv
// Scenario bench for tohost_monitor: a default-parameter instance and a
// short-timeout instance share the write port; results go through scoreboards.
module tb_tohost_monitor;

  localparam logic [31:0] TOHOST    = 32'h0000_1000;
  localparam int unsigned T_TIMEOUT = 50;

  typedef struct packed {
    logic        pass;
    logic        fail;
    logic        timeout;
    logic [30:0] test_num;
    logic [31:0] cycles;
  } res_t;

  logic clk;
  logic rst;
  logic run_en_a, run_en_t;

  logic        a_done, a_done_pulse, a_pass, a_fail, a_timeout;
  logic [30:0] a_test_num;
  logic [31:0] a_cycles;
  logic        t_done, t_done_pulse, t_pass, t_fail, t_timeout;
  logic [30:0] t_test_num;
  logic [31:0] t_cycles;

  res_t q_a[$];
  res_t q_t[$];
  res_t mon_a_exp, mon_a_act, mon_t_exp, mon_t_act;
  int   total = 0;
  int   bad   = 0;

  tohost_monitor_if wr_if ();

  tohost_monitor u_dut (
    .clk(clk), .rst(rst), .run_en(run_en_a), .wr(wr_if),
    .done(a_done), .done_pulse(a_done_pulse), .pass(a_pass), .fail(a_fail),
    .timeout(a_timeout), .test_num(a_test_num), .cycles(a_cycles)
  );

  tohost_monitor #(.TIMEOUT_CYCLES(T_TIMEOUT)) u_dut_to (
    .clk(clk), .rst(rst), .run_en(run_en_t), .wr(wr_if),
    .done(t_done), .done_pulse(t_done_pulse), .pass(t_pass), .fail(t_fail),
    .timeout(t_timeout), .test_num(t_test_num), .cycles(t_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog");
  end

  // Scoreboards: each done_pulse consumes one expected result.
  always @(negedge clk) begin
    if (a_done_pulse === 1'b1) begin
      total++;
      mon_a_act = '{pass: a_pass, fail: a_fail, timeout: a_timeout,
                    test_num: a_test_num, cycles: a_cycles};
      if (q_a.size() == 0) begin
        bad++;
        $display("FAIL sb_a_unexpected: got done with p/f/t=%b%b%b cycles=%0d, required no completion",
                 a_pass, a_fail, a_timeout, a_cycles);
      end else begin
        mon_a_exp = q_a.pop_front();
        if (mon_a_act !== mon_a_exp || a_done !== 1'b1) begin
          bad++;
          $display("FAIL sb_a_result: got done=%b p/f/t=%b%b%b num=%0d cycles=%0d, required done=1 p/f/t=%b%b%b num=%0d cycles=%0d",
                   a_done, a_pass, a_fail, a_timeout, a_test_num, a_cycles,
                   mon_a_exp.pass, mon_a_exp.fail, mon_a_exp.timeout,
                   mon_a_exp.test_num, mon_a_exp.cycles);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (t_done_pulse === 1'b1) begin
      total++;
      mon_t_act = '{pass: t_pass, fail: t_fail, timeout: t_timeout,
                    test_num: t_test_num, cycles: t_cycles};
      if (q_t.size() == 0) begin
        bad++;
        $display("FAIL sb_t_unexpected: got done with p/f/t=%b%b%b cycles=%0d, required no completion",
                 t_pass, t_fail, t_timeout, t_cycles);
      end else begin
        mon_t_exp = q_t.pop_front();
        if (mon_t_act !== mon_t_exp || t_done !== 1'b1) begin
          bad++;
          $display("FAIL sb_t_result: got done=%b p/f/t=%b%b%b num=%0d cycles=%0d, required done=1 p/f/t=%b%b%b num=%0d cycles=%0d",
                   t_done, t_pass, t_fail, t_timeout, t_test_num, t_cycles,
                   mon_t_exp.pass, mon_t_exp.fail, mon_t_exp.timeout,
                   mon_t_exp.test_num, mon_t_exp.cycles);
        end
      end
    end
  end

  function automatic res_t mk(input logic p, input logic f, input logic t,
                              input logic [30:0] tn, input logic [31:0] c);
    mk = '{pass: p, fail: f, timeout: t, test_num: tn, cycles: c};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_wr();
    wr_if.wr_valid = 1'b0;
    wr_if.wr_addr  = '0;
    wr_if.wr_data  = '0;
    wr_if.wr_strb  = '0;
  endtask

  task automatic drive_wr(input logic v, input logic [31:0] addr,
                          input logic [31:0] data, input logic [3:0] strb);
    wr_if.wr_valid = v;
    wr_if.wr_addr  = addr;
    wr_if.wr_data  = data;
    wr_if.wr_strb  = strb;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    run_en_a = 1'b0;
    run_en_t = 1'b0;
    idle_wr();
    q_a.delete();
    q_t.delete();
    repeat (2) tick();
    rst = 1'b0;
    tick();
  endtask

  // Bounded wait for a done pulse; steps past it so the scoreboard sees it.
  task automatic wait_done(input bit on_t, input string tag);
    int n = 0;
    while (((on_t ? t_done_pulse : a_done_pulse) !== 1'b1) && n < 20) begin
      tick();
      n++;
    end
    total++;
    if ((on_t ? t_done_pulse : a_done_pulse) !== 1'b1) begin
      bad++;
      $display("FAIL %s_wait_done: no done_pulse after %0d cycles, required within 20", tag, n);
    end
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({a_done, a_done_pulse, a_pass, a_fail, a_timeout, a_test_num, a_cycles} !== '0) begin
      bad++;
      $display("FAIL reset_a: got done=%b p/f/t=%b%b%b cycles=%0d, required all 0",
               a_done, a_pass, a_fail, a_timeout, a_cycles);
    end
    total++;
    if ({t_done, t_done_pulse, t_pass, t_fail, t_timeout, t_test_num, t_cycles} !== '0) begin
      bad++;
      $display("FAIL reset_t: got done=%b p/f/t=%b%b%b cycles=%0d, required all 0",
               t_done, t_pass, t_fail, t_timeout, t_cycles);
    end
    repeat (5) tick();
    total++;
    if (a_cycles !== 32'd0 || a_done !== 1'b0) begin
      bad++;
      $display("FAIL idle_no_count: got cycles=%0d done=%b, required 0 0", a_cycles, a_done);
    end
  endtask

  task automatic test_pass();
    do_reset();
    run_en_a = 1'b1;
    repeat (100) tick();
    total++;
    if (a_cycles !== 32'd99) begin
      bad++;
      $display("FAIL pass_precount: got cycles=%0d, required 99", a_cycles);
    end
    q_a.push_back(mk(1'b1, 1'b0, 1'b0, 31'd0, 32'd100));
    drive_wr(1'b1, TOHOST, 32'h1, 4'hF);
    tick();
    idle_wr();
    total++;
    if ({a_pass, a_fail, a_timeout, a_done} !== 4'b1000 || a_cycles !== 32'd100) begin
      bad++;
      $display("FAIL pass_decode: got p/f/t/done=%b%b%b%b cycles=%0d, required 1000 100",
               a_pass, a_fail, a_timeout, a_done, a_cycles);
    end
    tick();
    total++;
    if (a_done !== 1'b0) begin
      bad++;
      $display("FAIL pass_settle: got done=%b one cycle after decode, required 0", a_done);
    end
    tick();
    total++;
    if (a_done !== 1'b1 || a_done_pulse !== 1'b1) begin
      bad++;
      $display("FAIL pass_done_rise: got done=%b pulse=%b, required 1 1", a_done, a_done_pulse);
    end
    tick();
    total++;
    if (a_done !== 1'b1 || a_done_pulse !== 1'b0) begin
      bad++;
      $display("FAIL pass_pulse_width: got done=%b pulse=%b, required 1 0", a_done, a_done_pulse);
    end
    run_en_a = 1'b0;
    drive_wr(1'b1, TOHOST, 32'h7, 4'hF);
    repeat (5) tick();
    idle_wr();
    total++;
    if ({a_done, a_done_pulse, a_pass, a_fail, a_timeout} !== 5'b10100 || a_cycles !== 32'd100) begin
      bad++;
      $display("FAIL pass_hold: got done/pulse/p/f/t=%b%b%b%b%b cycles=%0d, required 10100 100",
               a_done, a_done_pulse, a_pass, a_fail, a_timeout, a_cycles);
    end
  endtask

  task automatic test_fail();
    logic [31:0] vals [2];
    int          wait_n [2];
    vals[0] = 32'h0000_0007; wait_n[0] = 10;
    vals[1] = 32'h8000_0003; wait_n[1] = 3;
    for (int i = 0; i < 2; i++) begin
      do_reset();
      run_en_a = 1'b1;
      repeat (wait_n[i]) tick();
      q_a.push_back(mk(1'b0, 1'b1, 1'b0, vals[i][31:1], 32'(wait_n[i])));
      drive_wr(1'b1, TOHOST, vals[i], 4'hF);
      tick();
      idle_wr();
      total++;
      if ({a_pass, a_fail, a_timeout} !== 3'b010 || a_test_num !== vals[i][31:1]) begin
        bad++;
        $display("FAIL fail_decode_%0d: got p/f/t=%b%b%b num=%h, required 010 num=%h",
                 i, a_pass, a_fail, a_timeout, a_test_num, vals[i][31:1]);
      end
      wait_done(1'b0, "fail");
    end
  endtask

  task automatic test_timeout();
    do_reset();
    run_en_t = 1'b1;
    q_t.push_back(mk(1'b0, 1'b0, 1'b1, 31'd0, 32'(T_TIMEOUT)));
    repeat (T_TIMEOUT) tick();
    total++;
    if (t_timeout !== 1'b0 || t_cycles !== 32'(T_TIMEOUT - 1)) begin
      bad++;
      $display("FAIL timeout_early: got timeout=%b cycles=%0d, required 0 %0d",
               t_timeout, t_cycles, T_TIMEOUT - 1);
    end
    tick();
    total++;
    if ({t_pass, t_fail, t_timeout, t_done} !== 4'b0010 || t_cycles !== 32'(T_TIMEOUT) ||
        t_test_num !== 31'd0) begin
      bad++;
      $display("FAIL timeout_fire: got p/f/t/done=%b%b%b%b cycles=%0d num=%0d, required 0010 %0d 0",
               t_pass, t_fail, t_timeout, t_done, t_cycles, t_test_num, T_TIMEOUT);
    end
    tick();
    total++;
    if (t_done !== 1'b0) begin
      bad++;
      $display("FAIL timeout_settle: got done=%b, required 0", t_done);
    end
    tick();
    total++;
    if (t_done !== 1'b1 || t_done_pulse !== 1'b1) begin
      bad++;
      $display("FAIL timeout_done: got done=%b pulse=%b, required 1 1", t_done, t_done_pulse);
    end
    repeat (3) tick();
    total++;
    if (t_cycles !== 32'(T_TIMEOUT)) begin
      bad++;
      $display("FAIL timeout_freeze: got cycles=%0d, required %0d", t_cycles, T_TIMEOUT);
    end
  endtask

  task automatic test_ignored();
    logic        v  [5];
    logic [31:0] ad [5];
    logic [31:0] dt [5];
    logic [3:0]  sb [5];
    v[0] = 1'b1; ad[0] = TOHOST;          dt[0] = 32'h1; sb[0] = 4'h3;
    v[1] = 1'b1; ad[1] = TOHOST;          dt[1] = 32'h0; sb[1] = 4'hF;
    v[2] = 1'b1; ad[2] = TOHOST;          dt[2] = 32'h2; sb[2] = 4'hF;
    v[3] = 1'b1; ad[3] = 32'h0000_1004;   dt[3] = 32'h1; sb[3] = 4'hF;
    v[4] = 1'b0; ad[4] = TOHOST;          dt[4] = 32'h1; sb[4] = 4'hF;
    do_reset();
    run_en_a = 1'b1;
    repeat (5) tick();
    for (int i = 0; i < 5; i++) begin
      drive_wr(v[i], ad[i], dt[i], sb[i]);
      tick();
      total++;
      if ({a_pass, a_fail, a_timeout, a_done} !== 4'b0000 || a_cycles !== 32'(5 + i)) begin
        bad++;
        $display("FAIL ignored_%0d: got p/f/t/done=%b%b%b%b cycles=%0d, required 0000 %0d",
                 i, a_pass, a_fail, a_timeout, a_done, a_cycles, 5 + i);
      end
    end
    q_a.push_back(mk(1'b1, 1'b0, 1'b0, 31'd0, 32'd10));
    drive_wr(1'b1, TOHOST, 32'h1, 4'hF);
    tick();
    idle_wr();
    wait_done(1'b0, "ignored");
  endtask

  task automatic test_back_to_back();
    do_reset();
    run_en_a = 1'b1;
    repeat (20) tick();
    q_a.push_back(mk(1'b1, 1'b0, 1'b0, 31'd0, 32'd20));
    drive_wr(1'b1, TOHOST, 32'h1, 4'hF);
    tick();
    drive_wr(1'b1, TOHOST, 32'h5, 4'hF);
    tick();
    idle_wr();
    total++;
    if (a_pass !== 1'b1 || a_fail !== 1'b0 || a_test_num !== 31'd0) begin
      bad++;
      $display("FAIL first_wins: got pass=%b fail=%b num=%0d, required 1 0 0",
               a_pass, a_fail, a_test_num);
    end
    wait_done(1'b0, "b2b");

    do_reset();
    run_en_t = 1'b1;
    repeat (T_TIMEOUT) tick();
    q_t.push_back(mk(1'b1, 1'b0, 1'b0, 31'd0, 32'(T_TIMEOUT)));
    drive_wr(1'b1, TOHOST, 32'h1, 4'hF);
    tick();
    idle_wr();
    total++;
    if ({t_pass, t_fail, t_timeout} !== 3'b100 || t_cycles !== 32'(T_TIMEOUT)) begin
      bad++;
      $display("FAIL write_beats_timeout: got p/f/t=%b%b%b cycles=%0d, required 100 %0d",
               t_pass, t_fail, t_timeout, t_cycles, T_TIMEOUT);
    end
    wait_done(1'b1, "edge");
  endtask

  task automatic test_reset_midrun();
    do_reset();
    run_en_a = 1'b1;
    repeat (3) tick();
    drive_wr(1'b1, TOHOST, 32'h1, 4'hF);
    tick();
    idle_wr();
    total++;
    if (a_pass !== 1'b1 || a_done !== 1'b0) begin
      bad++;
      $display("FAIL settle_entry: got pass=%b done=%b, required 1 0", a_pass, a_done);
    end
    rst = 1'b1;
    #1;
    total++;
    if ({a_done, a_done_pulse, a_pass, a_fail, a_timeout, a_test_num, a_cycles} !== '0) begin
      bad++;
      $display("FAIL rst_in_settle: got done=%b p/f/t=%b%b%b cycles=%0d, required all 0",
               a_done, a_pass, a_fail, a_timeout, a_cycles);
    end
    do_reset();
    run_en_a = 1'b1;
    repeat (4) tick();
    q_a.push_back(mk(1'b1, 1'b0, 1'b0, 31'd0, 32'd4));
    drive_wr(1'b1, TOHOST, 32'h1, 4'hF);
    tick();
    idle_wr();
    wait_done(1'b0, "rerun");
    tick();
    rst = 1'b1;
    #1;
    total++;
    if ({a_done, a_done_pulse, a_pass, a_fail, a_timeout, a_test_num, a_cycles} !== '0) begin
      bad++;
      $display("FAIL rst_in_done: got done=%b p/f/t=%b%b%b cycles=%0d, required all 0",
               a_done, a_pass, a_fail, a_timeout, a_cycles);
    end
    do_reset();
    run_en_a = 1'b1;
    repeat (6) tick();
    q_a.push_back(mk(1'b0, 1'b1, 1'b0, 31'd1, 32'd6));
    drive_wr(1'b1, TOHOST, 32'h3, 4'hF);
    tick();
    idle_wr();
    wait_done(1'b0, "after_rst");
  endtask

  task automatic test_pause();
    do_reset();
    run_en_a = 1'b1;
    repeat (10) tick();
    run_en_a = 1'b0;
    drive_wr(1'b1, TOHOST, 32'h5, 4'hF);
    tick();
    idle_wr();
    repeat (9) tick();
    total++;
    if (a_cycles !== 32'd9 || {a_pass, a_fail, a_timeout, a_done} !== 4'b0000) begin
      bad++;
      $display("FAIL pause_hold: got cycles=%0d p/f/t/done=%b%b%b%b, required 9 0000",
               a_cycles, a_pass, a_fail, a_timeout, a_done);
    end
    run_en_a = 1'b1;
    repeat (5) tick();
    total++;
    if (a_cycles !== 32'd14) begin
      bad++;
      $display("FAIL pause_resume: got cycles=%0d, required 14", a_cycles);
    end
    q_a.push_back(mk(1'b1, 1'b0, 1'b0, 31'd0, 32'd15));
    drive_wr(1'b1, TOHOST, 32'h1, 4'hF);
    tick();
    idle_wr();
    wait_done(1'b0, "pause");
  endtask

  initial begin
    rst      = 1'b1;
    run_en_a = 1'b0;
    run_en_t = 1'b0;
    idle_wr();
    test_reset();
    test_pass();
    test_fail();
    test_timeout();
    test_ignored();
    test_back_to_back();
    test_reset_midrun();
    test_pause();
    repeat (3) tick();
    total++;
    if (q_a.size() != 0 || q_t.size() != 0) begin
      bad++;
      $display("FAIL sb_drain: got %0d/%0d results outstanding, required 0/0",
               q_a.size(), q_t.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tohost_monitor.md
Name: tohost_monitor

Overview:
- Snoops the core's data-memory write port and detects riscv-tests completion, i.e. stores to the tohost word.
- Decodes the stored value into pass/fail plus failing test number, and flags a timeout if no completion arrives in time.
- Sits directly downstream of the core in every rv32ui-p-* bench. It replaces the fixed-tick gp check: the bench ends on `done` and writes `passed`/`failed` from `pass`.

Parameters:
TOHOST_ADDR, 32'h0000_1000, byte address of the tohost word (word aligned)
TIMEOUT_CYCLES, 5000, cycles in RUN before timeout is declared
SETTLE_CYCLES, 2, cycles waited after decode before asserting done (pipeline drain)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
run_en  in  1  level; monitor counts and snoops only while high
wr_valid  in  1  core data-memory write strobe, one store per cycle
wr_addr  in  32  store byte address
wr_data  in  32  store data
wr_strb  in  4  byte enables
done  out  1  sticky; result is final
done_pulse  out  1  single-cycle pulse on the cycle done rises
pass  out  1  sticky; tohost received 1
fail  out  1  sticky; tohost received odd value other than 1
timeout  out  1  sticky; TIMEOUT_CYCLES elapsed without a valid tohost write
test_num  out  31  failing test number (value>>1); 0 on pass or timeout
cycles  out  32  RUN cycles elapsed at the decode point, saturating

Behaviour:
- Reset (async, rst=1): state=IDLE. All outputs 0, counters 0. Reset mid-run discards any result.
- States:
  - IDLE: `run_en`=1 -> RUN on the next edge. The cycle counter starts at 0 in the first RUN cycle.
  - RUN, each cycle:
    - `cycles` increments, saturating at 32'hFFFF_FFFF.
    - Qualifying write: `wr_valid`=1, `wr_addr`==TOHOST_ADDR, `wr_strb`==4'hF, `wr_data[0]`=1.
    - On a qualifying write, latch the value and go to SETTLE. `cycles` freezes at the value including that cycle.
    - `wr_data`==1 -> pass. Other odd value -> fail, `test_num`=`wr_data[31:1]`.
    - Writes ignored: zero value, even nonzero value (syscall encoding), partial strobe, other address.
    - If `cycles` reaches TIMEOUT_CYCLES with no qualifying write -> timeout=1, go to SETTLE.
    - A qualifying write in the same cycle the timeout would fire wins: result is pass/fail, not timeout.
  - SETTLE: count SETTLE_CYCLES. Further tohost writes are ignored; the first write wins. Then go to DONE.
  - DONE: `done`=1 and `done_pulse` for exactly one cycle on entry. Outputs held until reset. `run_en` is ignored.
- `run_en` low in RUN: counter and snoop pause; state is held, not reset.
- pass, fail and timeout are mutually exclusive and become visible at once, registered on entry to SETTLE. Exactly one is set when `done`=1.
- No combinational paths from inputs to outputs.
- Address compare is a full 32-bit equality. Misaligned TOHOST_ADDR is an elaboration error (`$error` if `TOHOST_ADDR[1:0]`!=0).
- SETTLE_CYCLES=0: SETTLE is skipped and DONE is entered directly.

Decomposition:
- Shared package holds:
  - state encoding IDLE/RUN/SETTLE/DONE as 2-bit localparams;
  - tohost value decode constants: PASS_CODE=1, LSB-marker rule;
  - default TOHOST_ADDR, so the linker script and benches agree.
- One sub-module is natural: sat_counter (width, enable, clear, saturate flag). Reuse it for the RUN cycle count and the SETTLE count.

Test Plan:
1. Reset, `run_en`=1, sw 32'h1 to 32'h1000 at RUN cycle 100 -> after 2 settle cycles: done=1, pass=1, fail=0, test_num=0, cycles=100, done_pulse high one cycle.
2. sw 32'h0000_0007 to tohost -> fail=1, test_num=3, pass=0, timeout=0.
3. No tohost write, TIMEOUT_CYCLES=50 -> timeout=1 with cycles=50, then done 2 cycles later, test_num=0.
4. Ignored writes: sh (strb 4'h3) value 1, sw value 0, sw value 2, sw 1 to 32'h1004 -> no state change. A following sw 1 to tohost -> pass.
5. sw 1 then sw 5 to tohost on consecutive cycles -> pass stays 1, fail stays 0 (first write wins). Qualifying write on the exact timeout cycle -> pass, timeout=0.
6. Assert rst during SETTLE and again in DONE -> all outputs 0 immediately (async). A new run completes normally afterwards. `run_en` deasserted for 10 cycles mid-RUN -> `cycles` excludes the paused cycles.
